// File: rtl/pipe_add_sub.sv
`timescale 1ns/1ps
// Pipelined two's-complement adder/subtractor, one SLICE-bit slice resolved per stage.
// Latency: result visible STAGES-1 edges after the accepting edge (same edge for STAGES=1).
// Backpressure: per-stage valid/ready with bubble collapse; in_ready is combinational from out_ready and stage valids only.
module pipe_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    // A slice width that does not tile the operand is a build-time error.
    generate
        if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_check
            $error("pipe_add_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // Per-stage state. a_q/b_q carry the full operands so the upper slices and the
    // sign bits travel with the operation; lower bits of them are never read downstream.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q,  cy_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    // What each stage would load if it advances this cycle.
    logic [STAGES-1:0] src_v, src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];

    // go[k]: stage k loads this cycle (it is empty, or everything from k to the end is full and draining).
    logic [STAGES-1:0] go;

    // Advance chain: a stage can load unless it and every stage after it are full while the output stalls.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        go        = '0;
        for (int k = LAST; k >= 0; k--) begin
            full_tail = full_tail & vld_q[k];
            go[k]     = !full_tail || out_ready;
        end
    end

    // Stage inputs: stage 0 takes the ports (b inverted and carry-in set for subtract), others take the previous stage.
    always_comb begin
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_s[0] = '0;
        src_c[0] = sub;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = vld_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = sum_q[k-1];
            src_c[k] = cy_q[k-1];
        end
    end

    // Next state: each advancing stage resolves its own slice with the carry from the stage before.
    always_comb begin
        logic [SLICE:0] part;
        part  = '0;
        vld_d = vld_q;
        cy_d  = cy_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
        end
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, src_a[k][k*SLICE +: SLICE]}
                 + {1'b0, src_b[k][k*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, src_c[k]};
            if (go[k]) begin
                vld_d[k]                    = src_v[k];
                a_d[k]                      = src_a[k];
                b_d[k]                      = src_b[k];
                sum_d[k]                    = src_s[k];
                sum_d[k][k*SLICE +: SLICE]  = part[SLICE-1:0];
                cy_d[k]                     = part[SLICE];
            end
        end
    end

    // Stage registers; reset clears valids and data so the outputs read zero immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign in_ready  = go[0];
    assign out_valid = vld_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = cy_q[LAST];
    // Signed overflow: operands of equal sign (after b inversion) yielding a result of the other sign.
    assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                    && (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipe_add_sub.sv
`timescale 1ns/1ps
// Bench for pipe_add_sub: three configurations (16/4, 8/8, 32/1) share one driver; sel picks the active one.
// Directed vectors on 16/4, back-to-back stream, backpressure streams on all configs, reset mid-flight.
// Unselected instances see in_valid=0 and out_ready=1 so they stay drained.
module tb_pipe_add_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_in_valid, d_sub, d_out_ready;
    logic [31:0] d_a, d_b;
    int          sel;
    logic [2:0]  rdy_v, ov_v, co_v, of_v;
    logic [31:0] sum_v [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W = (g == 0) ? 16 : ((g == 1) ? 8 : 32);
        localparam int S = (g == 0) ? 4  : ((g == 1) ? 8 : 1);
        logic [W-1:0] sum_w;
        pipe_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (d_in_valid && (sel == g)),
            .in_ready  (rdy_v[g]),
            .a         (d_a[W-1:0]),
            .b         (d_b[W-1:0]),
            .sub       (d_sub),
            .out_valid (ov_v[g]),
            .out_ready (d_out_ready || (sel != g)),
            .sum       (sum_w),
            .cout      (co_v[g]),
            .ovf       (of_v[g])
        );
        assign sum_v[g] = 32'(sum_w);
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    function automatic int cfg_w(input int g);
        return (g == 0) ? 16 : ((g == 1) ? 8 : 32);
    endfunction

    function automatic int cfg_s(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 8 : 1);
    endfunction

    // Arithmetic reference: unsigned result for sum/cout, true signed result range test for ovf.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] x, input logic [31:0] y, input logic s);
        longint m, half, ux, uy, sx, sy, ru, rs;
        logic [63:0] rb;
        logic c, o;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ux   = longint'(x) & m;
        uy   = longint'(y) & m;
        sx   = (ux >= half) ? ux - (m + 1) : ux;
        sy   = (uy >= half) ? uy - (m + 1) : uy;
        ru   = s ? ux - uy : ux + uy;
        rs   = s ? sx - sy : sx + sy;
        c    = s ? (ux >= uy) : (ru > m);
        o    = (rs >= half) || (rs < -half);
        rb   = ru & m;
        return {c, o, rb[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input vec_t v);
        check({name, "_valid"}, 64'(ov_v[0]), 64'(1));
        check({name, "_sum"},   64'(sum_v[0]), 64'(v.sum));
        check({name, "_cout"},  64'(co_v[0]), 64'(v.cout));
        check({name, "_ovf"},   64'(of_v[0]), 64'(v.ovf));
    endtask

    // One isolated operation on the 16/4 instance: checks acceptance, latency and result.
    task automatic run_one(input string name, input vec_t v);
        @(negedge clk);
        sel         = 0;
        d_out_ready = 1'b1;
        d_a         = {16'h0, v.a};
        d_b         = {16'h0, v.b};
        d_sub       = v.sub;
        d_in_valid  = 1'b1;
        #1;
        check({name, "_in_ready"}, 64'(rdy_v[0]), 64'(1));
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        d_a        = 32'hA5A5_5A5A;
        d_b        = 32'h0F0F_F0F0;
        d_sub      = !v.sub;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            if (k == 3) check({name, "_early"}, 64'(ov_v[0]), 64'(0));
        end
        check_vec(name, v);
    endtask

    // 12 random ops back-to-back under the 1,0,0,1,1,0 out_ready pattern.
    task automatic run_stream(input int g);
        int          w, st, issued, delivered, inflight, first_acc, first_vis;
        logic [33:0] expq [$];
        logic [33:0] prev_out, cur_out;
        logic [31:0] ca, cb;
        logic        cs, need_new, prev_stall, exp_rdy, in_x, out_x;
        bit          pat [6];
        pat        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        w          = cfg_w(g);
        st         = cfg_s(g);
        issued     = 0;
        delivered  = 0;
        inflight   = 0;
        first_acc  = -1;
        first_vis  = -1;
        need_new   = 1'b1;
        prev_stall = 1'b0;
        prev_out   = '0;
        ca         = '0;
        cb         = '0;
        cs         = 1'b0;
        sel        = g;
        for (int n = 0; n < 400 && delivered < 12; n++) begin
            @(negedge clk);
            d_out_ready = pat[n % 6];
            if (issued < 12 && need_new) begin
                ca       = $urandom;
                cb       = $urandom;
                cs       = 1'($urandom_range(0, 1));
                need_new = 1'b0;
            end
            d_a        = ca;
            d_b        = cb;
            d_sub      = cs;
            d_in_valid = (issued < 12);
            #1;
            exp_rdy = !((inflight == st) && !d_out_ready);
            check("stream_in_ready", 64'(rdy_v[g]), 64'(exp_rdy));
            cur_out = {co_v[g], of_v[g], sum_v[g]};
            if (prev_stall) begin
                check("stream_hold_valid", 64'(ov_v[g]), 64'(1));
                check("stream_hold_data", 64'(cur_out), 64'(prev_out));
            end
            if (ov_v[g]) begin
                if (expq.size() == 0) begin
                    check("stream_spurious", 64'(ov_v[g]), 64'(0));
                end else begin
                    if (first_vis < 0) first_vis = n;
                    check("stream_result", 64'(cur_out), 64'(expq[0]));
                end
            end
            in_x       = d_in_valid && rdy_v[g];
            out_x      = ov_v[g] && d_out_ready;
            prev_stall = ov_v[g] && !d_out_ready;
            prev_out   = cur_out;
            if (out_x && expq.size() > 0) begin
                void'(expq.pop_front());
                delivered++;
                inflight--;
            end
            if (in_x) begin
                expq.push_back(ref_op(w, ca, cb, cs));
                if (first_acc < 0) first_acc = n;
                issued++;
                inflight++;
                need_new = 1'b1;
            end
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        check("stream_count", 64'(delivered), 64'(12));
        check("stream_latency", 64'(first_vis - first_acc), 64'(st));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        vec_t rv;
        vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};

        rst_n       = 1'b0;
        d_in_valid  = 1'b0;
        d_sub       = 1'b0;
        d_out_ready = 1'b1;
        d_a         = '0;
        d_b         = '0;
        sel         = 0;

        // Reset state, before any clock edge.
        #2;
        for (int g = 0; g < 3; g++) begin
            check("reset_out_valid", 64'(ov_v[g]), 64'(0));
            check("reset_sum",       64'(sum_v[g]), 64'(0));
            check("reset_cout",      64'(co_v[g]), 64'(0));
            check("reset_ovf",       64'(of_v[g]), 64'(0));
            check("reset_in_ready",  64'(rdy_v[g]), 64'(1));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Isolated directed vectors with latency check.
        for (int i = 0; i < 12; i++) run_one($sformatf("vec%0d", i), vecs[i]);

        // Same vectors back-to-back: one result per cycle, no bubbles.
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            sel         = 0;
            d_out_ready = 1'b1;
            if (n < 12) begin
                d_a        = {16'h0, vecs[n].a};
                d_b        = {16'h0, vecs[n].b};
                d_sub      = vecs[n].sub;
                d_in_valid = 1'b1;
            end else begin
                d_in_valid = 1'b0;
            end
            #1;
            if (n < 12) check("b2b_in_ready", 64'(rdy_v[0]), 64'(1));
            if (n < 4) check("b2b_idle", 64'(ov_v[0]), 64'(0));
            else       check_vec($sformatf("b2b%0d", n - 4), vecs[n - 4]);
        end

        // Backpressure streams on every configuration.
        for (int g = 0; g < 3; g++) run_stream(g);

        // Reset with three operations in flight and the first one stalled at the output.
        sel = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            d_out_ready = 1'b0;
            d_in_valid  = (n < 3);
            case (n)
                0:       begin d_a = 32'h8000; d_b = 32'h8001; d_sub = 1'b0; end
                1:       begin d_a = 32'h1111; d_b = 32'h2222; d_sub = 1'b0; end
                default: begin d_a = 32'h0FFF; d_b = 32'h0001; d_sub = 1'b1; end
            endcase
        end
        #1;
        check("prerst_valid", 64'(ov_v[0]), 64'(1));
        check("prerst_sum",   64'(sum_v[0]), 64'(16'h0001));
        check("prerst_cout",  64'(co_v[0]), 64'(1));
        check("prerst_ovf",   64'(of_v[0]), 64'(1));
        check("prerst_in_ready", 64'(rdy_v[0]), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid",    64'(ov_v[0]), 64'(0));
        check("midrst_sum",      64'(sum_v[0]), 64'(0));
        check("midrst_cout",     64'(co_v[0]), 64'(0));
        check("midrst_ovf",      64'(of_v[0]), 64'(0));
        check("midrst_in_ready", 64'(rdy_v[0]), 64'(1));
        @(negedge clk);
        rst_n       = 1'b1;
        d_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("postrst_no_stale", 64'(ov_v[0]), 64'(0));
            @(negedge clk);
        end
        rv = '{16'h4321, 16'h1234, 1'b1, 16'h30ED, 1'b1, 1'b0};
        run_one("postrst", rv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_add_sub.md
# pipe_add_sub

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on input and output. The WIDTH-bit operation is split into STAGES equal slices. One slice is resolved per pipeline stage, and the carry is registered between stages. This allows wide arithmetic at high clock rates with a throughput of one operation per cycle. It is the datapath arithmetic primitive that replaces chains of single-bit full adders in the arithmetic blocks.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); SLICE = WIDTH/STAGES bits are resolved per stage.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand set on a/b/sub is valid.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  0: compute a+b; 1: compute a−b.
- out_valid  output  1  result on sum/cout/ovf is valid.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. For subtraction this is the no-borrow flag (1 when a ≥ b unsigned).
- ovf  output  1  signed overflow.

## Operation
- Transfer rules:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Stage registers S0..S(STAGES−1). Each holds:
  - a valid bit;
  - the sum bits resolved so far;
  - the unresolved upper slices of a and the effective b;
  - the slice carry;
  - the operand sign bits.
- Stage 0 captures on an input transfer:
  - effective b = sub ? ~b : b; carry-in = sub.
  - Resolves bits [SLICE−1:0].
- Stage k resolves bits [(k+1)·SLICE−1 : k·SLICE] using the registered carry from stage k−1.
- The final stage drives sum, cout and ovf.
- Flag definitions:
  - cout = carry out of bit WIDTH−1.
  - ovf = (a[MSB] == effb[MSB]) && (sum[MSB] != a[MSB]).
- Advance rule: stage k loads from stage k−1 when stage k is empty or stage k is being emptied this cycle.
  - The final stage is emptied by an output transfer.
  - Bubbles collapse, so there is no global stall.
- in_ready = !S0.valid || S0 advances this cycle. It is combinational from out_ready through the stage valids; there is no combinational path from in_valid.
- When a stage advances and receives no new data, its valid clears and its data are don't-care.
- Capacity: STAGES operations in flight. Results leave in acceptance order; none are dropped or duplicated.
- out_valid may not deassert until an output transfer occurs. sum/cout/ovf stay stable while out_valid && !out_ready.
- a, b and sub are sampled only on an input transfer and are ignored otherwise.

## Timing
- Reset (rst_n low, asynchronous):
  - All stage valids = 0 and all data registers = 0, so out_valid = 0, sum = 0, cout = 0, ovf = 0.
  - in_ready = 1 combinationally while the pipeline is empty, including during reset.
- Reset mid-operation discards every in-flight operation; no partial result is ever presented.
- Release of rst_n is synchronised externally; the first transfer can occur at the first rising edge after release.
- Latency: an operation accepted at edge t has out_valid = 1 from just after edge t+STAGES−1, provided every stage is free. For STAGES=1, the result is visible right after the accepting edge.
- Throughput: with out_ready held high, one result per cycle with no bubbles.
- A full pipeline with out_ready high accepts a new input in the same cycle as the output transfer (simultaneous in/out).
- A full pipeline with out_ready low gives in_ready = 0. It recovers to 1 in the same cycle out_ready rises.
- Boundary parameters:
  - STAGES = WIDTH gives 1-bit slices.
  - WIDTH not divisible by STAGES is a configuration error and must fail elaboration.

## Test plan
- Parameters WIDTH=16, STAGES=4, out_ready=1:
  - a=0x1234, b=0x0FFF, sub=0 accepted at edge 0 -> sum=0x2233, cout=0, ovf=0 with out_valid high after edge 3.
  - a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0. This exercises the carry through all four slices.
- Subtraction:
  - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
- Backpressure stream:
  - Stimulus: 12 random ops issued back-to-back while out_ready follows the pattern 1,0,0,1,1,0,…
  - Required: all 12 results appear in order and match the reference model; outputs are held stable while stalled; in_ready=0 exactly when 4 ops are held and out_ready=0.
- Reset mid-flight: with 3 ops in flight, pulse rst_n low between edges -> out_valid, sum, cout and ovf go to 0 immediately with no clock edge. No stale result appears after release, and the next accepted op completes with correct latency.
- Re-run the streaming scenario with the parameters WIDTH=8, STAGES=8 and WIDTH=32, STAGES=1 -> the latency equals STAGES and the results are correct.
